mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative 32-bit multiply/divide unit (MULT/MULTU/DIV/DIVU) with HiLo write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic        HiLoEn,
    output logic [63:0] HiLoWrite
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_FIX     = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam logic [4:0] LAST_ITER = 5'd31;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] result_q, result_d;
    logic        is_div_q;
    logic        neg_q;
    logic        neg_rem_q;
    logic [31:0] a_q;
    logic [31:0] opnd_q;

    logic        w_signed, w_a_neg, w_b_neg, w_accept;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_sum;
    logic [31:0] w_mul_hi, w_mul_lo;
    logic [32:0] w_shifted;
    logic        w_fits;
    logic [31:0] w_trial, w_div_hi, w_div_lo;
    logic [63:0] w_prod, w_fix;

    assign w_signed = ~Op[0];
    assign w_a_neg  = w_signed & A[31];
    assign w_b_neg  = w_signed & B[31];
    assign w_a_mag  = w_a_neg ? (~A + 32'd1) : A;
    assign w_b_mag  = w_b_neg ? (~B + 32'd1) : B;
    assign w_accept = (state_q == S_IDLE) && Start;

    // Multiply: lo holds the multiplier and shifts out as the product fills in from the top.
    assign w_sum    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : 32'd0)};
    assign w_mul_hi = w_sum[32:1];
    assign w_mul_lo = {w_sum[0], lo_q[31:1]};

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient bits in.
    assign w_shifted = {hi_q, lo_q[31]};
    assign w_fits    = w_shifted >= {1'b0, opnd_q};
    assign w_trial   = w_shifted[31:0] - opnd_q;
    assign w_div_hi  = w_fits ? w_trial : w_shifted[31:0];
    assign w_div_lo  = {lo_q[30:0], w_fits};

    assign w_prod = {hi_q, lo_q};

    always_comb begin
        w_fix = 64'd0;
        if (!is_div_q) begin
            w_fix = neg_q ? (~w_prod + 64'd1) : w_prod;
        end else if (opnd_q == 32'd0) begin
            w_fix = {a_q, 32'hFFFF_FFFF};
        end else begin
            w_fix[63:32] = neg_rem_q ? (~hi_q + 32'd1) : hi_q;
            w_fix[31:0]  = neg_q     ? (~lo_q + 32'd1) : lo_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RUN;
                    cnt_d   = 5'd0;
                    hi_d    = 32'd0;
                    lo_d    = Op[1] ? w_a_mag : w_b_mag;
                end
            end
            S_RUN: begin
                hi_d  = is_div_q ? w_div_hi : w_mul_hi;
                lo_d  = is_div_q ? w_div_lo : w_mul_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = w_fix;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            result_q  <= 64'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= 32'd0;
            opnd_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            if (w_accept) begin
                is_div_q  <= Op[1];
                neg_q     <= w_a_neg ^ w_b_neg;
                neg_rem_q <= w_a_neg;
                a_q       <= A;
                opnd_q    <= Op[1] ? w_b_mag : w_a_mag;
            end
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign HiLoEn    = Done;
    assign HiLoWrite = result_q;
    assign Stall     = ~Reset & (w_accept || (state_q == S_RUN) || (state_q == S_FIX));

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed self-checking bench for mul_div_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        Clock, Reset, Start;
    logic [1:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Stall, Done, HiLoEn;
    logic [63:0] HiLoWrite;

    int checks = 0;
    int passes = 0;

    mul_div_unit dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Stall(Stall), .Done(Done), .HiLoEn(HiLoEn), .HiLoWrite(HiLoWrite)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Launch one operation, scramble inputs after latch, and wait for Done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int edges, output int stalls,
                          output logic done_stall, output logic en);
        Op = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; A = ~a; B = ~b; Op = ~op;
        edges = 1; stalls = 0;
        while (Done !== 1'b1 && edges < 40) begin
            if (Stall === 1'b1) stalls++;
            tick();
            edges++;
        end
        res = HiLoWrite; done_stall = Stall; en = HiLoEn;
        tick();
    endtask

    task automatic test_reset;
        Reset = 1'b0; Start = 1'b0; Op = 2'b00; A = 32'd0; B = 32'd0;
        #2 Reset = 1'b1; Start = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", Busy); else passes++;
        checks++; if ({Done, HiLoEn} !== 2'b00) $display("FAIL reset_done got=%b want=00", {Done, HiLoEn}); else passes++;
        checks++; if (HiLoWrite !== 64'd0) $display("FAIL reset_hilo got=%h want=0", HiLoWrite); else passes++;
        checks++; if (Stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", Stall); else passes++;
        tick(); tick();
        Start = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_multu_max;
        logic [63:0] res; int edges, stalls; logic ds, en;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, edges, stalls, ds, en);
        checks++; if (res !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_max got=%h want=fffffffe00000001", res); else passes++;
        checks++; if (edges !== 34) $display("FAIL multu_latency got=%0d want=34", edges); else passes++;
        checks++; if (stalls !== 33) $display("FAIL multu_stall_cycles got=%0d want=33", stalls); else passes++;
        checks++; if (ds !== 1'b0) $display("FAIL done_stall got=%b want=0", ds); else passes++;
        checks++; if (en !== 1'b1) $display("FAIL done_hiloen got=%b want=1", en); else passes++;
        checks++; if (Busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", Busy); else passes++;
        checks++; if (HiLoWrite !== 64'hFFFF_FFFE_0000_0001) $display("FAIL hold_result got=%h want=fffffffe00000001", HiLoWrite); else passes++;
    endtask

    task automatic test_vectors;
        logic [1:0]  ops  [9] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10};
        logic [31:0] as   [9] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFF9, 32'd100,
                                  32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FFF9};
        logic [31:0] bs   [9] = '{32'd7, 32'h8000_0000, 32'h10, 32'd2, 32'd0,
                                  32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'd0};
        logic [63:0] exps [9] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000, 64'h0000_0001_2345_6780,
                                  64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0064_FFFF_FFFF, 64'h0000_0000_8000_0000,
                                  64'h0000_0002_0000_000E, 64'h0000_0001_FFFF_FFFD, 64'hFFFF_FFF9_FFFF_FFFF};
        logic [63:0] res; int edges, stalls; logic ds, en;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], res, edges, stalls, ds, en);
            checks++;
            if (res !== exps[i] || edges !== 34)
                $display("FAIL vector_%0d got=%h/%0d want=%h/34", i, res, edges, exps[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_abort;
        bit seen = 1'b0;
        Op = 2'b01; A = 32'd5; B = 32'd6; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (10) tick();
        Reset = 1'b1; Start = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", Busy); else passes++;
        checks++; if (Stall !== 1'b0) $display("FAIL abort_stall got=%b want=0", Stall); else passes++;
        checks++; if (HiLoWrite !== 64'd0) $display("FAIL abort_hilo got=%h want=0", HiLoWrite); else passes++;
        tick();
        Start = 1'b0; Reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (HiLoEn === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) $display("FAIL abort_hiloen got=%b want=0", seen); else passes++;
        checks++; if (HiLoWrite !== 64'd0) $display("FAIL abort_hilo_after got=%h want=0", HiLoWrite); else passes++;
    endtask

    task automatic test_back_to_back;
        int n = 0;
        Op = 2'b01; A = 32'd2; B = 32'd3; Start = 1'b1;
        #1;
        checks++; if (Stall !== 1'b1) $display("FAIL start_stall got=%b want=1", Stall); else passes++;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        Start = 1'b1; A = 32'd7; B = 32'd9;
        tick();
        Start = 1'b0;
        while (Done !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (HiLoWrite !== 64'd6) $display("FAIL b2b_first got=%h want=6", HiLoWrite); else passes++;
        Start = 1'b1; A = 32'd4; B = 32'd5; Op = 2'b01;
        #1;
        checks++; if (Stall !== 1'b0) $display("FAIL done_start_stall got=%b want=0", Stall); else passes++;
        tick();
        checks++; if ({Busy, Done, Stall} !== 3'b001) $display("FAIL ignored_in_done got=%b want=001", {Busy, Done, Stall}); else passes++;
        tick();
        Start = 1'b0; A = 32'd0; B = 32'd0;
        checks++; if (Busy !== 1'b1) $display("FAIL idle_accept got=%b want=1", Busy); else passes++;
        n = 1;
        while (Done !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 34) $display("FAIL b2b_latency got=%0d want=34", n); else passes++;
        checks++; if (HiLoWrite !== 64'd20) $display("FAIL b2b_second got=%h want=14", HiLoWrite); else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_vectors();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
